// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer, clocked from the PLL reference oscillator.
// Pulses the PLL RESET pin, waits for LOCK, requires LOCK to stay stable
// before releasing the system reset, re-runs the PLL on timeout or lock loss,
// and goes to a sticky FAULT after MAX_RETRIES failed lock attempts.
// Optional feature macro: LOCK_LOSS_COUNT_EN builds the saturating
// lock-loss counter; without it o_lock_loss_count is tied to zero.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 270000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_lock,
  output logic       o_pll_rst,
  output logic       o_sys_rst,
  output logic       o_locked,
  output logic       o_fault,
  output logic [7:0] o_lock_loss_count
);

  // One shared counter serves every timed state, so size it for the longest.
  localparam int MAX_A   = (PLL_RST_CYCLES > TIMEOUT_CYCLES) ? PLL_RST_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_LIM = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [7:0]             r_retries;
  logic [7:0]             w_retries_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;

  logic r_pll_rst, r_sys_rst, r_locked, r_fault;
  logic w_pll_rst_nxt, w_sys_rst_nxt, w_locked_nxt, w_fault_nxt;

  // LOCK is asynchronous to the oscillator: bring it in through a flop chain.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pll_lock};
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Next-state, counter and retry updates.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_retries_nxt = r_retries;
    case (r_state)
      S_PLL_RESET: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          // Lock seen wins over a timeout landing on the same cycle.
          w_state_nxt = S_STABILIZE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_retries_nxt = r_retries + 8'd1;
          w_cnt_nxt     = '0;
          w_state_nxt   = (w_retries_nxt == RETRY_LIM) ? S_FAULT : S_PLL_RESET;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STABILIZE: begin
        if (!w_lock_s) begin
          // A dropout before release is a glitch: restart the lock wait.
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt   = S_RUN;
          w_cnt_nxt     = '0;
          w_retries_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt   = S_PLL_RESET;
          w_cnt_nxt     = '0;
          w_retries_nxt = '0;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt   = S_PLL_RESET;
        w_cnt_nxt     = '0;
        w_retries_nxt = '0;
      end
    endcase
  end

  // Moore decode of the next state so the registered outputs move with it.
  always_comb begin
    w_pll_rst_nxt = 1'b0;
    w_sys_rst_nxt = 1'b1;
    w_locked_nxt  = 1'b0;
    w_fault_nxt   = 1'b0;
    case (w_state_nxt)
      S_PLL_RESET: w_pll_rst_nxt = 1'b1;
      S_RUN: begin
        w_sys_rst_nxt = 1'b0;
        w_locked_nxt  = 1'b1;
      end
      S_FAULT:     w_fault_nxt = 1'b1;
      default:     ;
    endcase
  end

  // State, counters and output registers; reset beats every transition.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_PLL_RESET;
      r_cnt     <= '0;
      r_retries <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_locked  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_retries <= w_retries_nxt;
      r_pll_rst <= w_pll_rst_nxt;
      r_sys_rst <= w_sys_rst_nxt;
      r_locked  <= w_locked_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign o_pll_rst = r_pll_rst;
  assign o_sys_rst = r_sys_rst;
  assign o_locked  = r_locked;
  assign o_fault   = r_fault;

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] r_lock_loss_count;
  logic       w_loss_evt;

  assign w_loss_evt = (r_state == S_RUN) && !w_lock_s;

  // Saturating count of lock drops observed while running.
  always_ff @(posedge i_clk) begin
    if (i_reset)                                   r_lock_loss_count <= 8'd0;
    else if (w_loss_evt && r_lock_loss_count != 8'hFF) r_lock_loss_count <= r_lock_loss_count + 8'd1;
  end

  assign o_lock_loss_count = r_lock_loss_count;
`else
  assign o_lock_loss_count = 8'd0;
`endif

endmodule
